// File: rtl/ahb2_arbiter_if.sv
// Arbiter-facing AHB2 signal bundle: requests and address-phase control in,
// grants and owner indices out.
interface ahb2_arbiter_if #(
    parameter int NUM_MST = 4,
    parameter int MW      = $clog2(NUM_MST)
);
    logic [NUM_MST-1:0] hbusreq;
    logic [NUM_MST-1:0] hlock;
    logic [1:0]         htrans;
    logic [2:0]         hburst;
    logic               hready;
    logic [NUM_MST-1:0] hgrant;
    logic [MW-1:0]      hmaster;
    logic [MW-1:0]      hmaster_d;
    logic               hmastlock;

    // Arbiter side
    modport slave (
        input  hbusreq, hlock, htrans, hburst, hready,
        output hgrant, hmaster, hmaster_d, hmastlock
    );

    // Requesting masters / bus fabric side
    modport master (
        output hbusreq, hlock, htrans, hburst, hready,
        input  hgrant, hmaster, hmaster_d, hmastlock
    );
endinterface

// File: rtl/ahb2_arbiter.sv
// Burst-aware round-robin AHB2 arbiter: fixed-length bursts and locked
// sequences keep the bus; grant moves during the final beat's address phase.
module ahb2_arbiter #(
    parameter int NUM_MST     = 4,
    parameter int DEFAULT_MST = 0,
    parameter int MW          = $clog2(NUM_MST)
) (
    input  logic          hclk,
    input  logic          hreset,
    ahb2_arbiter_if.slave bus
);
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [MW-1:0]      DEF_IDX   = MW'(DEFAULT_MST);
    localparam logic [NUM_MST-1:0] DEF_GRANT = NUM_MST'(1) << DEFAULT_MST;

    logic [NUM_MST-1:0] hgrant_reg;
    logic [NUM_MST-1:0] hgrant_next;
    logic [MW-1:0]      hmaster_reg;
    logic [MW-1:0]      hmaster_d_reg;
    logic               hmastlock_reg;
    logic [MW-1:0]      last_reg;
    logic [4:0]         cnt_reg;
    logic [4:0]         cnt_next;
    logic [MW-1:0]      grant_idx;
    logic [MW-1:0]      winner;
    logic [MW-1:0]      cand;
    logic               found;
    logic               hold_lock;
    logic               arb_ok;

    // Beats still to go after the current address phase.
    always_comb begin
        cnt_next = cnt_reg;
        if (bus.hready) begin
            case (bus.htrans)
                HTRANS_NONSEQ: begin
                    case (bus.hburst)
                        3'b010, 3'b011: cnt_next = 5'd3;
                        3'b100, 3'b101: cnt_next = 5'd7;
                        3'b110, 3'b111: cnt_next = 5'd15;
                        default:        cnt_next = 5'd0;
                    endcase
                end
                HTRANS_SEQ:  cnt_next = (cnt_reg != 5'd0) ? cnt_reg - 5'd1 : 5'd0;
                HTRANS_IDLE: cnt_next = 5'd0;
                default:     cnt_next = cnt_reg;
            endcase
        end
    end

    assign hold_lock = bus.hlock[hmaster_reg] & bus.hbusreq[hmaster_reg];
    assign arb_ok    = bus.hready & ~hold_lock & (cnt_next <= 5'd1);

    // Rotating search starting just after the last winner; last is visited last.
    always_comb begin
        winner = DEF_IDX;
        found  = 1'b0;
        cand   = '0;
        for (int k = 1; k <= NUM_MST; k++) begin
            cand = MW'((int'(last_reg) + k) % NUM_MST);
            if (!found && bus.hbusreq[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    assign hgrant_next = NUM_MST'(1) << winner;

    // One-hot to index: bit gi of the index is set by any grant whose position has bit gi set.
    for (genvar gi = 0; gi < MW; gi++) begin : g_enc
        logic [NUM_MST-1:0] sel_mask;
        for (genvar gj = 0; gj < NUM_MST; gj++) begin : g_bit
            assign sel_mask[gj] = ((gj >> gi) & 1) != 0;
        end
        assign grant_idx[gi] = |(hgrant_reg & sel_mask);
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            hgrant_reg    <= DEF_GRANT;
            hmaster_reg   <= DEF_IDX;
            hmaster_d_reg <= DEF_IDX;
            hmastlock_reg <= 1'b0;
            last_reg      <= DEF_IDX;
            cnt_reg       <= 5'd0;
        end else if (bus.hready) begin
            cnt_reg       <= cnt_next;
            hmaster_reg   <= grant_idx;
            hmaster_d_reg <= hmaster_reg;
            hmastlock_reg <= bus.hlock[grant_idx] & bus.hbusreq[grant_idx];
            if (arb_ok) begin
                hgrant_reg <= hgrant_next;
                // Parking on the default master does not move the pointer.
                if (found) begin
                    last_reg <= winner;
                end
            end
        end
    end

    assign bus.hgrant    = hgrant_reg;
    assign bus.hmaster   = hmaster_reg;
    assign bus.hmaster_d = hmaster_d_reg;
    assign bus.hmastlock = hmastlock_reg;
endmodule
